el2_exu_alu_noc_sched: RTL

Scheduler sharing the single NoC path to the remote ALU node between NUM_REQ EXU requesters. It round-robin arbitrates operand packets onto the serial sender and keeps exactly one transaction in flight. It routes the returning result from the ALU result receiver back to the owning requester. It also drives `noc_sr_flush` to abort the link on pipeline flush or response timeout.

---
 rtl/el2_exu_alu_noc_sched_if.sv | 41 ++++
 rtl/el2_exu_alu_noc_sched.sv | 128 ++++++++++++
 2 files changed

// File: rtl/el2_exu_alu_noc_sched_if.sv
// Bundle of the requester, serial-sender, result-receiver and response
// signals shared between the scheduler and its environment.
//
// Handshakes: a transfer on a valid/ready pair happens in a cycle where both
// are high at the rising clock edge. A valid, once raised, holds its payload
// stable until that cycle. rx_valid and rsp_valid are single-cycle strobes
// with no ready.
interface el2_exu_alu_noc_sched_if #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 64,
    parameter int RESULT_W  = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_valid;
    logic [PAYLOAD_W-1:0]         tx_payload;
    logic                         tx_ready;
    logic                         rx_valid;
    logic [RESULT_W-1:0]          rx_result;
    logic                         flush;
    logic                         noc_sr_flush;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [RESULT_W-1:0]          rsp_result;
    logic                         busy;
    logic                         timeout_err;

    // Environment side: requesters, sender, receiver and pipeline control.
    modport master (
        output req_valid, req_payload, tx_ready, rx_valid, rx_result, flush,
        input  req_ready, tx_valid, tx_payload, noc_sr_flush, rsp_valid,
               rsp_result, busy, timeout_err
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_payload, tx_ready, rx_valid, rx_result, flush,
        output req_ready, tx_valid, tx_payload, noc_sr_flush, rsp_valid,
               rsp_result, busy, timeout_err
    );
endinterface

// File: rtl/el2_exu_alu_noc_sched.sv
// Shares the single NoC path to the remote ALU between NUM_REQ requesters.
// Round-robin arbitration, one transaction in flight, result routed back to
// the owner, link abort on pipeline flush or response timeout.
module el2_exu_alu_noc_sched #(
    parameter int NUM_REQ        = 2,
    parameter int PAYLOAD_W      = 64,
    parameter int RESULT_W       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_noc,
    input  logic                     rst_l,
    el2_exu_alu_noc_sched_if.slave   bus,
    output logic [1:0]               state_dbg
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        WAIT  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t               state, next_state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     owner;
    logic [TIMER_W-1:0]   timer;
    logic [PAYLOAD_W-1:0] tx_payload_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [RESULT_W-1:0]  rsp_result_q;
    logic                 timeout_err_q;

    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     cand;
    logic                 grant;
    logic                 rsp_fire;
    logic                 timeout_fire;

    // Round-robin pick: first pending requester scanning upward from ptr+1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Accept only from IDLE, never during reset or a pipeline flush.
    assign grant = (state == IDLE) && rst_l && !bus.flush && found;

    // Next state; flush in SEND/WAIT overrides tx_ready, rx_valid and timeout.
    always_comb begin
        next_state   = state;
        rsp_fire     = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (grant) next_state = SEND;
            end
            SEND: begin
                if (bus.flush)         next_state = ABORT;
                else if (bus.tx_ready) next_state = WAIT;
            end
            WAIT: begin
                if (bus.flush) begin
                    next_state = ABORT;
                end else if (bus.rx_valid) begin
                    next_state = IDLE;
                    rsp_fire   = 1'b1;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state   = ABORT;
                    timeout_fire = 1'b1;
                end
            end
            ABORT: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus the datapath registers it controls.
    always_ff @(posedge clk_noc) begin
        if (!rst_l) begin
            state         <= IDLE;
            ptr           <= PTR_W'(NUM_REQ - 1);
            owner         <= '0;
            timer         <= '0;
            tx_payload_q  <= '0;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (grant) begin
                tx_payload_q <= bus.req_payload[int'(winner)*PAYLOAD_W +: PAYLOAD_W];
                owner        <= winner;
                ptr          <= winner;
            end
            // Timer restarts on WAIT entry and saturates instead of wrapping.
            if (state == SEND && next_state == WAIT) begin
                timer <= '0;
            end else if (state == WAIT && timer != {TIMER_W{1'b1}}) begin
                timer <= timer + 1'b1;
            end
            rsp_valid_q <= rsp_fire ? (NUM_REQ'(1) << owner) : '0;
            if (rsp_fire) rsp_result_q <= bus.rx_result;
            timeout_err_q <= timeout_fire;
        end
    end

    assign bus.req_ready    = grant ? (NUM_REQ'(1) << winner) : '0;
    assign bus.tx_valid     = (state == SEND);
    assign bus.tx_payload   = tx_payload_q;
    assign bus.noc_sr_flush = (state == ABORT);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.busy         = (state != IDLE);
    assign bus.timeout_err  = timeout_err_q;
    assign state_dbg        = state;
endmodule
